// File: rtl/multicycle_ctrl.sv
// LEGv8 multi-cycle control FSM with instruction/data memory ready handshakes.
// Define MC_PERF_CNT_EN to add the RetireCnt retired-instruction counter.
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [10:0] InstrOp,
    input  logic        InstRdy,
    input  logic        DataRdy,
    input  logic        Zero,
    output logic        InstReq,
    output logic        DataReq,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic [1:0]  SignOp,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        InstDone,
    output logic        Illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [RETIRE_W-1:0] RetireCnt
`endif
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

    typedef enum logic [2:0] {
        K_RTYPE, K_ADDI, K_LDUR, K_STUR, K_CBZ, K_B, K_BAD
    } kind_t;

    state_t      state;
    logic [10:0] op_q;
    kind_t       kind;

    always_comb begin
        kind = K_BAD;
        unique casez (op_q)
            11'b11111000010: kind = K_LDUR;
            11'b11111000000: kind = K_STUR;
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: kind = K_RTYPE;
            11'b1001000100?: kind = K_ADDI;
            11'b10110100???: kind = K_CBZ;
            11'b000101?????: kind = K_B;
            default:         kind = K_BAD;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= IDLE;
            op_q  <= '0;
        end else begin
            unique case (state)
                IDLE:   state <= FETCH;
                FETCH: begin
                    if (InstRdy) begin
                        op_q  <= InstrOp;
                        state <= DECODE;
                    end
                end
                DECODE: state <= (kind == K_BAD) ? TRAP : EXEC;
                EXEC: begin
                    unique case (kind)
                        K_LDUR, K_STUR: state <= MEM;
                        K_CBZ, K_B:     state <= FETCH;
                        default:        state <= WB;
                    endcase
                end
                MEM: begin
                    if (DataRdy)
                        state <= (kind == K_LDUR) ? WB : FETCH;
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state; IRWrite, PCWrite and MEM retire are Mealy.
    always_comb begin
        InstReq  = 1'b0;
        DataReq  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        SignOp   = 2'b00;
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 2'b00;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        InstDone = 1'b0;
        Illegal  = 1'b0;
        unique case (state)
            FETCH: begin
                InstReq = 1'b1;
                IRWrite = InstRdy;
                PCWrite = InstRdy;
            end
            EXEC: begin
                unique case (kind)
                    K_RTYPE: ALUOp = 2'b10;
                    K_ADDI:  ALUSrc = 1'b1;
                    K_LDUR:  ALUSrc = 1'b1;
                    K_STUR: begin
                        ALUSrc  = 1'b1;
                        Reg2Loc = 1'b1;
                    end
                    K_CBZ: begin
                        Reg2Loc  = 1'b1;
                        ALUOp    = 2'b01;
                        PCSrc    = 1'b1;
                        PCWrite  = Zero;
                        InstDone = 1'b1;
                    end
                    K_B: begin
                        PCSrc    = 1'b1;
                        PCWrite  = 1'b1;
                        InstDone = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                DataReq  = 1'b1;
                MemRead  = (kind == K_LDUR);
                MemWrite = (kind == K_STUR);
                InstDone = DataRdy && (kind == K_STUR);
            end
            WB: begin
                RegWrite = 1'b1;
                MemToReg = (kind == K_LDUR);
                InstDone = 1'b1;
            end
            TRAP:    Illegal = 1'b1;
            default: ;
        endcase
        if (state inside {DECODE, EXEC, MEM, WB}) begin
            unique case (kind)
                K_ADDI:  SignOp = 2'b01;
                K_CBZ:   SignOp = 2'b10;
                K_B:     SignOp = 2'b11;
                default: SignOp = 2'b00;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    localparam logic [RETIRE_W-1:0] CNT_ONE = RETIRE_W'(1);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L)
            RetireCnt <= '0;
        else if (InstDone && state != TRAP)
            RetireCnt <= RetireCnt + CNT_ONE;
    end
`else
    logic [RETIRE_W-1:0] unused_retire;
    assign unused_retire = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against per-instruction totals
// (latency, strobe counts, SignOp) derived from the LEGv8 opcode table.
module tb_multicycle_ctrl;

    localparam int RW = 16;
    localparam int K_R = 0, K_ADDI = 1, K_LD = 2, K_ST = 3;
    localparam int K_CBZ = 4, K_B = 5, K_BAD = 6;

    logic        CLK, Reset_L;
    logic [10:0] InstrOp;
    logic        InstRdy, DataRdy, Zero;
    logic        InstReq, DataReq, MemRead, MemWrite, IRWrite;
    logic        PCWrite, PCSrc, Reg2Loc, ALUSrc;
    logic        MemToReg, RegWrite, InstDone, Illegal;
    logic [1:0]  SignOp, ALUOp;
`ifdef MC_PERF_CNT_EN
    logic [RW-1:0] RetireCnt;
`endif
    logic [15:0] strobes;

    int checks, errors, ret_exp, pre_cycles;

    assign strobes = {InstReq, DataReq, MemRead, MemWrite, IRWrite,
                      PCWrite, PCSrc, SignOp, Reg2Loc, ALUSrc, ALUOp,
                      MemToReg, RegWrite, InstDone};

    multicycle_ctrl #(.RETIRE_W(RW)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .InstrOp(InstrOp),
        .InstRdy(InstRdy), .DataRdy(DataRdy), .Zero(Zero),
        .InstReq(InstReq), .DataReq(DataReq), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .SignOp(SignOp), .Reg2Loc(Reg2Loc),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .InstDone(InstDone), .Illegal(Illegal)
`ifdef MC_PERF_CNT_EN
        , .RetireCnt(RetireCnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int kind_of(input logic [10:0] op);
        if (op == 11'b11111000010) return K_LD;
        if (op == 11'b11111000000) return K_ST;
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return K_R;
        if (op ==? 11'b1001000100?) return K_ADDI;
        if (op ==? 11'b10110100???) return K_CBZ;
        if (op ==? 11'b000101?????) return K_B;
        return K_BAD;
    endfunction

    function automatic logic [1:0] sign_of(input int k);
        case (k)
            K_ADDI:  return 2'b01;
            K_CBZ:   return 2'b10;
            K_B:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [10:0] make_op(input int k);
        logic [10:0] rt [4];
        rt[0] = 11'b10001011000;
        rt[1] = 11'b11001011000;
        rt[2] = 11'b10001010000;
        rt[3] = 11'b10101010000;
        case (k)
            K_R:     return rt[$urandom_range(0, 3)];
            K_ADDI:  return {10'b1001000100, 1'($urandom)};
            K_LD:    return 11'b11111000010;
            K_ST:    return 11'b11111000000;
            K_CBZ:   return {8'b10110100, 3'($urandom)};
            default: return {6'b000101, 5'($urandom)};
        endcase
    endfunction

    task automatic do_reset();
        Reset_L = 1'b0;
        InstRdy = 1'($urandom);
        DataRdy = 1'($urandom);
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (strobes !== 16'h0 || Illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs got %h/%b want 0/0", strobes, Illegal);
        end
        @(posedge CLK);
        #2 Reset_L = 1'b1;
        ret_exp = 0;
    endtask

    // Runs one instruction with fw fetch waits and mw memory waits.
    task automatic run_instr(input logic [10:0] op, input int fw,
                             input int mw, input logic z, input string tag);
        int k, fc, mc, lat, pre, sbad, ndone;
        int n_req, n_ir, n_pcw, n_br, n_dreq, n_mr, n_mw;
        int n_als, n_rw, n_m2r, n_r2l;
        int e_lat, e_pcw, e_br, e_mem, e_rw;
        bit started, fin, ill;
        bit is_mem;
        k = kind_of(op);
        {fc, mc, lat, pre, sbad, ndone} = '0;
        {n_req, n_ir, n_pcw, n_br, n_dreq, n_mr, n_mw} = '0;
        {n_als, n_rw, n_m2r, n_r2l} = '0;
        started = 0; fin = 0; ill = 0;
        for (int c = 0; c < 80 && !fin; c++) begin
            @(negedge CLK);
            if (InstReq) begin
                InstRdy = (fc == fw);
                InstrOp = InstRdy ? op : 11'($urandom);
                fc++;
            end else begin
                InstRdy = 1'($urandom);
                InstrOp = 11'($urandom);
            end
            if (DataReq) begin
                DataRdy = (mc == mw);
                mc++;
            end else begin
                DataRdy = 1'($urandom);
            end
            Zero = (ALUOp == 2'b01) ? z : 1'($urandom);
            #1;
            if (InstReq) started = 1;
            if (!started) pre++;
            else lat++;
            n_req  += int'(InstReq);
            n_ir   += int'(IRWrite);
            n_pcw  += int'(PCWrite);
            n_br   += int'(PCWrite && PCSrc);
            n_dreq += int'(DataReq);
            n_mr   += int'(MemRead);
            n_mw   += int'(MemWrite);
            n_als  += int'(ALUSrc);
            n_rw   += int'(RegWrite);
            n_m2r  += int'(MemToReg);
            n_r2l  += int'(Reg2Loc);
            if (started && !InstReq && !Illegal && k != K_BAD &&
                SignOp !== sign_of(k)) sbad++;
            if (InstDone === 1'b1) begin
                ndone++;
                fin = 1;
`ifdef MC_PERF_CNT_EN
                checks++;
                if (RetireCnt !== RW'(ret_exp)) begin
                    errors++;
                    $display("FAIL %s retire got %0d want %0d",
                             tag, RetireCnt, ret_exp);
                end
`endif
                ret_exp++;
            end
            if (Illegal === 1'b1) begin
                ill = 1;
                fin = 1;
            end
        end
        pre_cycles = pre;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout op=%b got no end want end", tag, op);
        end
        if (k == K_BAD) begin
            checks++;
            if (!ill || ndone != 0 || lat != fw + 3 || n_rw != 0 ||
                n_pcw != 1) begin
                errors++;
                $display("FAIL %s trap op=%b got ill=%0d done=%0d lat=%0d rw=%0d pcw=%0d want 1 0 %0d 0 1",
                         tag, op, ill, ndone, lat, n_rw, n_pcw, fw + 3);
            end
            return;
        end
        is_mem = (k == K_LD || k == K_ST);
        e_lat = (k == K_B || k == K_CBZ) ? 3 : (k == K_LD) ? 5 : 4;
        e_lat += fw + (is_mem ? mw : 0);
        e_br  = (k == K_B) ? 1 : (k == K_CBZ) ? int'(z) : 0;
        e_pcw = 1 + e_br;
        e_mem = is_mem ? mw + 1 : 0;
        e_rw  = (k == K_R || k == K_ADDI || k == K_LD) ? 1 : 0;
        checks++;
        if (ill || ndone != 1) begin
            errors++;
            $display("FAIL %s retire op=%b got ill=%0d done=%0d want 0 1",
                     tag, op, ill, ndone);
        end
        checks++;
        if (lat != e_lat) begin
            errors++;
            $display("FAIL %s latency op=%b got %0d want %0d",
                     tag, op, lat, e_lat);
        end
        checks++;
        if (n_req != fw + 1 || n_ir != 1) begin
            errors++;
            $display("FAIL %s fetch got req=%0d ir=%0d want %0d 1",
                     tag, n_req, n_ir, fw + 1);
        end
        checks++;
        if (n_pcw != e_pcw || n_br != e_br) begin
            errors++;
            $display("FAIL %s pc got pcw=%0d br=%0d want %0d %0d",
                     tag, n_pcw, n_br, e_pcw, e_br);
        end
        checks++;
        if (n_dreq != e_mem || n_mr != (k == K_LD ? e_mem : 0) ||
            n_mw != (k == K_ST ? e_mem : 0)) begin
            errors++;
            $display("FAIL %s mem got req=%0d rd=%0d wr=%0d want %0d",
                     tag, n_dreq, n_mr, n_mw, e_mem);
        end
        checks++;
        if (n_rw != e_rw || n_m2r != int'(k == K_LD)) begin
            errors++;
            $display("FAIL %s wb got rw=%0d m2r=%0d want %0d %0d",
                     tag, n_rw, n_m2r, e_rw, int'(k == K_LD));
        end
        checks++;
        if (n_als != int'(k == K_ADDI || is_mem) ||
            n_r2l != int'(k == K_ST || k == K_CBZ)) begin
            errors++;
            $display("FAIL %s exec got alusrc=%0d r2l=%0d want %0d %0d",
                     tag, n_als, n_r2l, int'(k == K_ADDI || is_mem),
                     int'(k == K_ST || k == K_CBZ));
        end
        checks++;
        if (sbad != 0) begin
            errors++;
            $display("FAIL %s signop got %0d bad cycles want 0 (op=%b)",
                     tag, sbad, op);
        end
    endtask

    task automatic test_reset();
        Reset_L = 1'b0;
        InstRdy = 1'b1;
        DataRdy = 1'b1;
        Zero    = 1'b1;
        InstrOp = 11'b10001011000;
        #3;
        checks++;
        if (strobes !== 16'h0 || Illegal !== 1'b0) begin
            errors++;
            $display("FAIL por_outs got %h/%b want 0/0", strobes, Illegal);
        end
        do_reset();
    endtask

    task automatic test_add();
        run_instr(11'b10001011000, 0, 0, 1'b0, "add");
        checks++;
        if (pre_cycles != 1) begin
            errors++;
            $display("FAIL add_idle got %0d want 1", pre_cycles);
        end
    endtask

    task automatic test_ldur();
        run_instr(11'b11111000010, 0, 3, 1'b0, "ldur");
    endtask

    task automatic test_cbz();
        run_instr(11'b10110100101, 0, 0, 1'b1, "cbz_taken");
        run_instr(11'b10110100010, 1, 0, 1'b0, "cbz_not");
    endtask

    task automatic test_b_addi();
        run_instr(11'b00010110011, 0, 0, 1'b0, "b");
        run_instr(11'b10010001001, 2, 0, 1'b0, "addi");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 5);
            run_instr(make_op(k), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom), "rand");
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(negedge CLK);
            InstRdy = InstReq;
            InstrOp = 11'b11111000000;
            DataRdy = 1'b0;
            Zero    = 1'b0;
            #1;
            if (DataReq) seen++;
        end
        checks++;
        if (seen != 2 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem got seen=%0d wr=%b want 2 1",
                     seen, MemWrite);
        end
        #2 Reset_L = 1'b0;
        #1;
        checks++;
        if (strobes !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got %h want 0", strobes);
        end
        @(posedge CLK);
        #2 Reset_L = 1'b1;
        ret_exp = 0;
`ifdef MC_PERF_CNT_EN
        checks++;
        if (RetireCnt !== '0) begin
            errors++;
            $display("FAIL mid_cnt got %0d want 0", RetireCnt);
        end
`endif
        run_instr(11'b11111000000, 1, 1, 1'b0, "refetch");
        checks++;
        if (pre_cycles != 1) begin
            errors++;
            $display("FAIL refetch_idle got %0d want 1", pre_cycles);
        end
    endtask

    task automatic test_trap();
        logic [10:0] op;
        for (int t = 0; t < 3; t++) begin
            op = 11'h7ff;
            if (t > 0) begin
                op = 11'($urandom);
                while (kind_of(op) != K_BAD) op = 11'($urandom);
            end
            run_instr(op, $urandom_range(0, 2), 0, 1'b0, "trap");
            for (int c = 0; c < 10; c++) begin
                @(negedge CLK);
                InstRdy = 1'($urandom);
                DataRdy = 1'($urandom);
                Zero    = 1'($urandom);
                #1;
                checks++;
                if (strobes !== 16'h0 || Illegal !== 1'b1) begin
                    errors++;
                    $display("FAIL trap_hold got %h/%b want 0/1",
                             strobes, Illegal);
                end
            end
`ifdef MC_PERF_CNT_EN
            checks++;
            if (RetireCnt !== RW'(ret_exp)) begin
                errors++;
                $display("FAIL trap_cnt got %0d want %0d",
                         RetireCnt, ret_exp);
            end
`endif
            do_reset();
            run_instr(make_op($urandom_range(0, 5)), 0, 1, 1'b1,
                      "post_trap");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ret_exp = 0;
        pre_cycles = 0;
        test_reset();
        test_add();
        test_ldur();
        test_cbz();
        test_b_addi();
        test_random();
        test_reset_mid();
        test_trap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the LEGv8 processor.
- Sequences fetch/decode/execute/memory/writeback with ready handshakes to instruction and data memory.
- Drives every datapath strobe, and generates the 2-bit SignOp select for the sign extender (00 D-type imm9, 01 I-type imm12, 10 CB imm19, 11 B imm26).
- Traps on unsupported opcodes.

Parameters:
- RETIRE_W, 32, width of the retire counter (used only with MC_PERF_CNT_EN).

Ports:
- CLK  in  1  rising-edge clock.
- Reset_L  in  1  asynchronous active-low reset.
- InstrOp  in  11  instruction memory read data bits [31:21]; valid while InstRdy=1.
- InstRdy  in  1  instruction memory data valid.
- DataRdy  in  1  data memory access complete.
- Zero  in  1  ALU zero flag; valid in EXEC.
- InstReq  out  1  instruction fetch request.
- DataReq  out  1  data memory request.
- MemRead  out  1  data read.
- MemWrite  out  1  data write.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  update PC.
- PCSrc  out  1  0 = PC+4, 1 = branch target.
- SignOp  out  2  sign-extender select.
- Reg2Loc  out  1  1 = read port 2 uses Rt (STUR/CBZ).
- ALUSrc  out  1  1 = immediate operand.
- ALUOp  out  2  00 add, 01 pass-B, 10 R-type function.
- MemToReg  out  1  1 = writeback from memory.
- RegWrite  out  1  register file write.
- InstDone  out  1  one-cycle retire pulse.
- Illegal  out  1  sticky trap flag.
- RetireCnt  out  RETIRE_W  retired instruction count (only with MC_PERF_CNT_EN).

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset_L low: state=IDLE, opcode latch=0, all outputs 0, SignOp=00.
- IDLE: all strobes 0. Moves to FETCH on the next clock unconditionally.
- FETCH: InstReq=1.
  - Holds while InstRdy=0.
  - On a cycle with InstRdy=1: IRWrite=1, PCWrite=1, PCSrc=0, InstrOp latched internally; next state DECODE.
- DECODE: classify the latched opcode.
  - LDUR 11111000010, STUR 11111000000: SignOp=00.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: SignOp don't-care, held at 00.
  - ADDI 1001000100x: SignOp=01.
  - CBZ 10110100xxx: SignOp=10.
  - B 000101xxxxx: SignOp=11.
  - Any other opcode: next state TRAP. Otherwise next state EXEC.
  - SignOp is combinational from the latched opcode and held from DECODE until the next FETCH.
- EXEC:
  - R-type: ALUSrc=0, ALUOp=10. Next WB.
  - ADDI: ALUSrc=1, ALUOp=00. Next WB.
  - LDUR/STUR: ALUSrc=1, ALUOp=00; Reg2Loc=1 for STUR. Next MEM.
  - CBZ: Reg2Loc=1, ALUOp=01, PCSrc=1, PCWrite=Zero (Mealy), InstDone=1. Next FETCH.
  - B: PCSrc=1, PCWrite=1, InstDone=1. Next FETCH.
- MEM: DataReq=1; MemRead=1 for LDUR, MemWrite=1 for STUR; strobes held while DataRdy=0.
  - DataRdy=1, LDUR: next WB.
  - DataRdy=1, STUR: InstDone=1, next FETCH.
- WB: RegWrite=1 for one cycle; MemToReg=1 for LDUR only; InstDone=1. Next FETCH.
- Latency with zero-wait memory: B/CBZ 3 cycles, R-type/ADDI/STUR 4, LDUR 5. Each memory wait cycle adds 1.
- TRAP: Illegal=1, all strobes 0. Stays in TRAP until reset; the trapping instruction does not retire.
- Ready inputs sampled only in their own states; InstRdy/DataRdy outside FETCH/MEM are ignored.
- Reset asserted mid-instruction: immediate return to IDLE, no strobes; the partial instruction is discarded.

Optional Feature:
- MC_PERF_CNT_EN defined:
  - RetireCnt port exists; reset 0.
  - Increments by 1 on every cycle with InstDone=1; wraps from all-ones to 0.
  - Frozen in TRAP.
- MC_PERF_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, InstRdy=1 with ADD → IDLE, FETCH(IRWrite, PCWrite), DECODE, EXEC(ALUOp=10), WB(RegWrite=1, InstDone=1); 5 cycles from reset release, 4 from FETCH.
- LDUR with DataRdy low for 3 MEM cycles → MemRead held 4 cycles; WB has MemToReg=1, RegWrite=1; SignOp=00 from DECODE.
- CBZ with Zero=1, then Zero=0 → SignOp=10; PCWrite=1/PCSrc=1 in EXEC for the first, PCWrite=0 for the second; InstDone=1 both.
- B, then ADDI → SignOp=11 then 01; B retires in 3 cycles; ADDI drives ALUSrc=1 in EXEC.
- Opcode 11111111111 → TRAP, Illegal=1; InstReq stays 0 for 10 cycles; Reset_L pulse clears Illegal.
- Reset_L pulled low during MEM of STUR → MemWrite drops in the same cycle; after release, refetch; RetireCnt (MC_PERF_CNT_EN) is 0.
